// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an I-cache and a D-cache.
// A dirty D miss runs a write-back phase followed by the refill read.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_raddr,
    input  logic [ADDR_W-1:0] d_waddr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {IDLE, I_RD, D_WB, D_RD, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_d;     // 1 when D won the most recent grant
    logic              resp_d;     // requester owning the current transaction
    logic              d_rd_pend;
    logic [ADDR_W-1:0] d_raddr_q;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        d_req     = d_ren | d_wen;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that did not win last time is granted.
                if (d_req && (!i_ren || !last_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = d_wen ? D_WB : D_RD;
                end else if (i_ren) begin
                    grant_i   = 1'b1;
                    state_nxt = I_RD;
                end
            end
            I_RD: begin
                mem_read = 1'b1;
                if (mem_ready) state_nxt = RESP;
            end
            D_WB: begin
                mem_write = 1'b1;
                if (mem_ready) state_nxt = d_rd_pend ? D_RD : RESP;
            end
            D_RD: begin
                mem_read = 1'b1;
                if (mem_ready) state_nxt = RESP;
            end
            RESP: begin
                i_ready   = ~resp_d;
                d_ready   = resp_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b0;
            resp_d    <= 1'b0;
            d_rd_pend <= 1'b0;
            d_raddr_q <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_i) begin
                mem_addr <= i_addr;
                last_d   <= 1'b0;
                resp_d   <= 1'b0;
            end
            if (grant_d) begin
                mem_addr  <= d_wen ? d_waddr : d_raddr;
                mem_wdata <= d_wdata;
                d_raddr_q <= d_raddr;
                d_rd_pend <= d_ren;
                last_d    <= 1'b1;
                resp_d    <= 1'b1;
            end
            // Refill address is switched in only once the write-back completes.
            if (state == D_WB && mem_ready && d_rd_pend) mem_addr <= d_raddr_q;
            if (state == I_RD && mem_ready) i_rdata <= mem_rdata;
            if (state == D_RD && mem_ready) d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts grant order,
// memory phases, ready pulses and read data, checked cycle by cycle.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_ren = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_ren = 1'b0;
    logic          d_wen = 1'b0;
    logic [AW-1:0] d_raddr = '0;
    logic [AW-1:0] d_waddr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_raddr(d_raddr), .d_waddr(d_waddr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit            m_last_d = 1'b0;
    logic [DW-1:0] m_irdata = '0;
    logic [DW-1:0] m_drdata = '0;
    int            force_lat = -1;
    bit            force_rd_en = 1'b0;
    logic [DW-1:0] force_rd = '0;

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (i_ready && d_ready) begin
                miscompares++;
                $display("FAIL ready_exclusive: i_ready=%0b d_ready=%0b both set", i_ready, d_ready);
            end
            vectors++;
            if (mem_read && mem_write) begin
                miscompares++;
                $display("FAIL strobe_exclusive: mem_read=%0b mem_write=%0b both set", mem_read, mem_write);
            end
        end
    end

    // Serves every request currently driven; entered and left at a negedge with DUT in IDLE.
    task automatic run_traffic(input bit churn);
        bit            ph_w [2];
        logic [AW-1:0] ph_a [2];
        logic [DW-1:0] ph_d [2];
        int            nph;
        bit            win_d;
        int            lat;
        logic [DW-1:0] rd;
        while (i_ren || d_ren || d_wen) begin
            win_d    = (d_ren || d_wen) && (!i_ren || !m_last_d);
            m_last_d = win_d;
            nph = 0;
            if (!win_d) begin
                ph_w[0] = 1'b0; ph_a[0] = i_addr; ph_d[0] = '0; nph = 1;
            end else begin
                if (d_wen) begin ph_w[nph] = 1'b1; ph_a[nph] = d_waddr; ph_d[nph] = d_wdata; nph++; end
                if (d_ren) begin ph_w[nph] = 1'b0; ph_a[nph] = d_raddr; ph_d[nph] = '0; nph++; end
            end
            for (int p = 0; p < nph; p++) begin
                lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
                for (int c = 0; c <= lat; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (mem_read !== !ph_w[p] || mem_write !== ph_w[p]) begin
                        miscompares++;
                        $display("FAIL phase_strobe: read=%0b write=%0b expected read=%0b write=%0b",
                                 mem_read, mem_write, !ph_w[p], ph_w[p]);
                    end
                    vectors++;
                    if (mem_addr !== ph_a[p]) begin
                        miscompares++;
                        $display("FAIL phase_addr: got %0h expected %0h", mem_addr, ph_a[p]);
                    end
                    if (ph_w[p]) begin
                        vectors++;
                        if (mem_wdata !== ph_d[p]) begin
                            miscompares++;
                            $display("FAIL phase_wdata: got %0h expected %0h", mem_wdata, ph_d[p]);
                        end
                    end
                    vectors++;
                    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL busy_ready: i_ready=%0b d_ready=%0b expected 0 0", i_ready, d_ready);
                    end
                    if (c == lat) begin
                        rd = force_rd_en ? force_rd : rand_line();
                        mem_ready = 1'b1;
                        mem_rdata = rd;
                        if (!ph_w[p]) begin
                            if (win_d) m_drdata = rd;
                            else       m_irdata = rd;
                        end
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = rand_line();
                    end
                    if (churn) begin
                        i_addr  = rand_addr();
                        d_raddr = rand_addr();
                        d_waddr = rand_addr();
                        d_wdata = rand_line();
                    end
                end
            end
            @(negedge clk);
            vectors++;
            if (i_ready !== !win_d || d_ready !== win_d) begin
                miscompares++;
                $display("FAIL resp_ready: i_ready=%0b d_ready=%0b expected %0b %0b",
                         i_ready, d_ready, !win_d, win_d);
            end
            vectors++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL resp_strobe: read=%0b write=%0b expected 0 0", mem_read, mem_write);
            end
            vectors++;
            if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin
                miscompares++;
                $display("FAIL resp_rdata: i=%0h d=%0h expected i=%0h d=%0h", i_rdata, d_rdata, m_irdata, m_drdata);
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = rand_line();
            if (win_d) begin d_ren = 1'b0; d_wen = 1'b0; end
            else       i_ren = 1'b0;
            @(negedge clk);
            vectors++;
            if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_quiet: i_ready=%0b d_ready=%0b read=%0b write=%0b expected all 0",
                         i_ready, d_ready, mem_read, mem_write);
            end
            mem_ready = 1'($urandom_range(0, 1));
        end
        mem_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ctrl: read=%0b write=%0b i_ready=%0b d_ready=%0b expected all 0",
                     tag, mem_read, mem_write, i_ready, d_ready);
        end
        vectors++;
        if (i_rdata !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL %s_data: i_rdata=%0h d_rdata=%0h addr=%0h wdata=%0h expected all 0",
                     tag, i_rdata, d_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        m_last_d = 1'b0; m_irdata = '0; m_drdata = '0;
        @(negedge clk);
        check_zero_outputs("after_reset");
    endtask

    // Assumes no transaction since the last reset, so the address/data registers are still zero.
    task automatic test_spurious();
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1'b1;
            mem_rdata = rand_line();
            @(negedge clk);
            check_zero_outputs("spurious");
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_i_only();
        i_ren = 1'b1;
        i_addr = 28'h0000010;
        force_lat = 1;
        force_rd_en = 1'b1;
        force_rd = {16{8'hA5}};
        run_traffic(1'b0);
        force_lat = -1;
        force_rd_en = 1'b0;
    endtask

    task automatic test_tie();
        i_ren = 1'b1; i_addr = rand_addr();
        d_ren = 1'b1; d_raddr = rand_addr();
        run_traffic(1'b0);
        d_ren = 1'b1; d_raddr = rand_addr();
        run_traffic(1'b0);
        i_ren = 1'b1; i_addr = rand_addr();
        d_ren = 1'b1; d_raddr = rand_addr();
        run_traffic(1'b0);
    endtask

    task automatic test_dirty_miss();
        d_wen = 1'b1; d_waddr = 28'h100; d_wdata = rand_line();
        d_ren = 1'b1; d_raddr = 28'h200;
        run_traffic(1'b0);
    endtask

    task automatic test_churn();
        i_ren = 1'b1; i_addr = rand_addr();
        d_wen = 1'b1; d_waddr = rand_addr(); d_wdata = rand_line();
        d_ren = 1'b1; d_raddr = rand_addr();
        run_traffic(1'b1);
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] wa;
        wa = rand_addr();
        d_wen = 1'b1; d_waddr = wa; d_wdata = rand_line();
        d_ren = 1'b1; d_raddr = rand_addr();
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (mem_write !== 1'b1 || mem_addr !== wa) begin
                miscompares++;
                $display("FAIL mid_wb: write=%0b addr=%0h expected 1 %0h", mem_write, mem_addr, wa);
            end
        end
        rst = 1'b1;
        d_wen = 1'b0; d_ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b0; m_irdata = '0; m_drdata = '0;
        check_zero_outputs("reset_mid");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_zero_outputs("post_abort");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            i_ren = 1'($urandom_range(0, 1));
            d_ren = 1'($urandom_range(0, 1));
            d_wen = 1'($urandom_range(0, 1));
            i_addr = rand_addr(); d_raddr = rand_addr(); d_waddr = rand_addr();
            d_wdata = rand_line();
            run_traffic(1'($urandom_range(0, 1)));
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_spurious();
        test_i_only();
        test_tie();
        test_dirty_miss();
        test_churn();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 28, memory line address width; DATA_W, 128, memory line data width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_ren  in  1  I-cache line read request.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  DATA_W  I-cache read line.
- i_ready  out  1  I-cache transaction done.
- d_ren  in  1  D-cache line read request.
- d_wen  in  1  D-cache line write-back request.
- d_raddr  in  ADDR_W  D-cache read address.
- d_waddr  in  ADDR_W  D-cache write-back address.
- d_wdata  in  DATA_W  D-cache write-back line.
- d_rdata  out  DATA_W  D-cache read line.
- d_ready  out  1  D-cache transaction done.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  one-cycle completion pulse from memory.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, I_RD, D_WB, D_RD, RESP.
REQ-004 In IDLE, with no request, the block SHALL stay in IDLE and hold every memory strobe low.
REQ-005 Arbitration SHALL be round-robin:
- A single last-winner flag SHALL select the winner when both caches request in the same IDLE cycle.
- The side that did not win last SHALL be granted.
- The flag SHALL reset to I, so D wins the first tie.
REQ-006 On grant, the block SHALL capture addresses and wdata into internal registers, and SHALL drive mem_addr and mem_wdata only from those registers for the whole transaction.
REQ-007 On an I grant, the FSM SHALL go IDLE->I_RD, drive mem_read=1 with mem_addr=captured i_addr, and hold this until mem_ready.
REQ-008 On a D grant, the next state SHALL depend on the request:
- d_wen=1: IDLE->D_WB.
- d_ren=1 only: IDLE->D_RD.
REQ-009 In D_WB the block SHALL drive mem_write=1 with mem_addr=d_waddr and mem_wdata=d_wdata (captured values). On mem_ready it SHALL go to D_RD if d_ren was captured as 1, else to RESP.
REQ-010 In D_RD the block SHALL drive mem_read=1 with mem_addr=captured d_raddr; on mem_ready it SHALL go to RESP.
REQ-011 On mem_ready during I_RD or D_RD, the block SHALL register mem_rdata into the winner's rdata output; that value SHALL hold until the next read completes for the same requester.
REQ-012 RESP SHALL last exactly one cycle, with the winner's ready=1 and every memory strobe low, and SHALL return to IDLE. Requests SHALL NOT be sampled in RESP.
REQ-013 The i_ready and d_ready outputs SHALL never both be 1 in the same cycle, and SHALL be 0 outside RESP.
REQ-014 The mem_read and mem_write strobes SHALL never both be 1 in the same cycle.
REQ-015 While the FSM is not in IDLE, the block SHALL ignore the requester inputs and mem_ready is meaningful only in I_RD, D_WB and D_RD. A mem_ready in IDLE or RESP SHALL be ignored.
REQ-016 Minimum latency from request to ready SHALL be 3 cycles for a single transaction (grant edge, mem_ready in first busy cycle, RESP). A write-back plus read SHALL take two busy phases.
REQ-017 The last-winner flag SHALL update on grant, not on completion.

Reset
REQ-018 When rst=1 at a clock edge, including mid-transaction, the block SHALL apply the following:
- state->IDLE, last-winner->I.
- mem_read, mem_write, i_ready, d_ready SHALL be 0.
- i_rdata, d_rdata, mem_addr, mem_wdata SHALL be 0.
- Any in-flight transaction SHALL be abandoned without a ready pulse.

Verification
REQ-019 I only: i_ren=1, i_addr=0x0000010, mem_ready on 2nd busy cycle, mem_rdata=0xA5..A5 -> mem_read high 2 cycles, then i_ready=1 one cycle, i_rdata=0xA5..A5.
REQ-020 Tie after reset: i_ren=d_ren=1 same cycle -> D served first (D_RD), then I served; on a second simultaneous tie, I served first.
REQ-021 D dirty miss: d_wen=d_ren=1, d_waddr=0x100, d_raddr=0x200 -> mem_write with mem_addr=0x100, then mem_read with mem_addr=0x200, then a single d_ready pulse and d_rdata=mem_rdata.
REQ-022 Input churn: change i_addr/d_wdata during the busy phase -> mem_addr and mem_wdata unchanged until RESP.
REQ-023 Reset mid D_WB: rst=1 for one cycle -> next cycle IDLE, all strobes and readies 0, no d_ready afterwards without a new request.
REQ-024 Spurious mem_ready in IDLE -> no state change and no ready pulse; throughout all tests, the invariants of REQ-013 and REQ-014 SHALL hold every cycle.
